split_slave: RTL and testbench
==============================

// Module: split_slave
// PURPOSE
//  Bus slave sitting downstream of Bus: consumes scl_n, HADDR, WDATA, sb_masters, sb_mastlock; returns RDATA, resp, sb_split_ar.
//  Local word memory with fast and slow regions; slow unlocked accesses are SPLIT, completed in background, then released to the arbiter.
// PARAMETERS
//  DATA_W     32     data width
//  ADDR_W     14     HADDR width; HADDR[13:12] decoded upstream, offset = HADDR[11:0]
//  MEM_AW     8      memory depth 2^MEM_AW words
//  FAST_WAIT  1      wait cycles, offset < SLOW_BASE
//  SLOW_WAIT  6      wait cycles, offset >= SLOW_BASE
//  SLOW_BASE  8'h80  first slow-region offset
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous active-low reset
//  scl          in   1       slave select (from decoder)
//  hwrite       in   1       1 write, 0 read
//  HADDR        in   ADDR_W  address
//  WDATA        in   DATA_W  write data
//  sb_masters   in   2       current owner: 01 M1, 10 M2
//  sb_mastlock  in   1       owner holds lock
//  RDATA        out  DATA_W  read data, valid when hready=1 & resp=00 on read
//  resp         out  2       00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
//  hready       out  1       1 = response cycle / idle
//  sb_split_ar  out  2       split release to arbiter: 01 M1, 10 M2
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE, RDATA=0, resp=00, hready=1, sb_split_ar=00, pending split cleared; memory contents kept.
//  Reset mid-transaction aborts it; an uncommitted write is dropped.
//  States: IDLE, BUSY, RESP, SPLIT, SBUSY, SREL, SDONE.
//  IDLE: scl=1 at edge T captures addr/wdata/hwrite/master/lock.
//   - HADDR[11:MEM_AW]!=0 -> RESP with resp=01 next cycle, no write.
//   - fast, or slow with sb_mastlock=1 -> BUSY, counter=wait; hready=0.
//   - slow, unlocked -> SPLIT.
//  BUSY: counter decrements; at 0 -> RESP. Response cycle = T+1+wait.
//  RESP: one cycle, hready=1, resp=00, write committed at this edge, RDATA=mem[addr] for reads; -> IDLE.
//  SPLIT: one cycle hready=1, resp=11; -> SBUSY, counter=SLOW_WAIT.
//  SBUSY: counts down; write commits / read data latched at 0; -> SREL.
//  SREL: sb_split_ar=captured master for exactly one cycle; -> SDONE.
//  SDONE: holds result until pending master re-accesses:
//   - scl=1, sb_masters=pending, same addr & hwrite -> next cycle resp=00 with stored data, pending cleared, -> IDLE.
//   - any other access -> next cycle resp=10 (RETRY), hready=1, no memory effect, stay SDONE.
//  Access during SPLIT/SBUSY/SREL: resp=10 that cycle, ignored.
//  scl ignored in BUSY/RESP (masters must not issue while hready=0).
//  SLOW_WAIT=0 in SBUSY: release next cycle. Only one split pending at a time.
//  resp/RDATA registered; resp returns to 00 in any non-response cycle.
// CONFIGURATION
//  SLAVE_SPLIT_EN defined: split path as above.
//  SLAVE_SPLIT_EN undefined: SPLIT/SBUSY/SREL/SDONE removed; slow accesses take BUSY with SLOW_WAIT; sb_split_ar tied 00; resp never 11 or 10.
// TESTING
//  Reset: rst=0 two cycles -> resp=00, hready=1, sb_split_ar=00, RDATA=0.
//  Fast write 0x10=0xA5 then read 0x10 by M1 -> hready=0 one cycle each, resp=00, RDATA=0xA5 at T+2.
//  Slow read 0x90 by M2 unlocked -> resp=11 at T+1, sb_split_ar=10 one cycle at T+8; re-read -> resp=00, correct data.
//  Split pending for M2, M1 reads 0x10 -> resp=10, memory unchanged; sb_split_ar stays 00.
//  Slow write 0x90=0x3C by M1 with sb_mastlock=1 -> no split, hready=0 six cycles, resp=00 at T+7.
//  Offset 0x200 (out of range) -> resp=01 at T+1, memory unchanged; rst=0 during SBUSY -> IDLE, write dropped.

Source files
------------

// File: rtl/split_slave.sv
// Purpose: bus slave with a fast/slow word memory; slow unlocked accesses are SPLIT and finished in the background.
// Latency: response sampled FAST_WAIT+1 / SLOW_WAIT+1 cycles after the request edge; a split read returns on re-access after release.
// Backpressure: hready=0 while a wait-stated access runs; accesses during a split get RETRY. Split path enabled by `define SLAVE_SPLIT_EN.
module split_slave #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 14,
    parameter int                MEM_AW    = 8,
    parameter int                FAST_WAIT = 1,
    parameter int                SLOW_WAIT = 6,
    parameter logic [MEM_AW-1:0] SLOW_BASE = 8'h80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [1:0]        sb_masters,
    input  logic              sb_mastlock,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        resp,
    output logic              hready,
    output logic [1:0]        sb_split_ar
);

`ifdef SLAVE_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    // Offset field below the upstream region decode; bits above MEM_AW must be zero.
    localparam int OFF_W = 12;

    localparam logic [1:0] R_OKAY  = 2'b00;
    localparam logic [1:0] R_ERROR = 2'b01;
    localparam logic [1:0] R_RETRY = 2'b10;
    localparam logic [1:0] R_SPLIT = 2'b11;

    localparam logic [7:0] FAST_W8 = 8'(FAST_WAIT);
    localparam logic [7:0] SLOW_W8 = 8'(SLOW_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_RESP,
        S_SPLIT,
        S_SBUSY,
        S_SREL,
        S_SDONE
    } state_t;

    state_t              state;
    logic [7:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                wr_q;
    logic [1:0]          master_q;
    logic [DATA_W-1:0]   split_dat;

    logic [DATA_W-1:0]   mem [2**MEM_AW];

    logic                off_bad;
    logic                is_slow;
    logic                do_split;
    logic [7:0]          acc_wait;
    logic [MEM_AW-1:0]   idx_in;
    logic [MEM_AW-1:0]   idx_q;
    logic                same_req;

    logic                mem_we;
    logic [MEM_AW-1:0]   mem_widx;
    logic [DATA_W-1:0]   mem_wdat;

    assign idx_in   = HADDR[MEM_AW-1:0];
    assign idx_q    = addr_q[MEM_AW-1:0];
    assign off_bad  = |HADDR[OFF_W-1:MEM_AW];
    assign is_slow  = (idx_in >= SLOW_BASE);
    assign do_split = SPLIT_EN && is_slow && !sb_mastlock;
    assign acc_wait = is_slow ? SLOW_W8 : FAST_W8;
    assign same_req = (sb_masters == master_q) && (HADDR == addr_q) && (hwrite == wr_q);

    // Single memory write port: zero-wait writes commit from the live bus, others from the captured request.
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = idx_q;
        mem_wdat = wdata_q;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if (scl && hwrite && !off_bad && !do_split && (acc_wait == 8'd0)) begin
                        mem_we   = 1'b1;
                        mem_widx = idx_in;
                        mem_wdat = WDATA;
                    end
                end
                S_BUSY: begin
                    if (wr_q && (cnt <= 8'd1)) begin
                        mem_we = 1'b1;
                    end
                end
                S_SBUSY: begin
                    if (SPLIT_EN && wr_q && (cnt <= 8'd1)) begin
                        mem_we = 1'b1;
                    end
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    // Memory array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    // Transaction FSM with registered bus response and split release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            master_q    <= 2'b00;
            split_dat   <= '0;
            RDATA       <= '0;
            resp        <= R_OKAY;
            hready      <= 1'b1;
            sb_split_ar <= 2'b00;
        end else begin
            // Non-response cycles fall back to an idle OKAY with no release.
            resp        <= R_OKAY;
            hready      <= 1'b1;
            sb_split_ar <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (scl) begin
                        addr_q   <= HADDR;
                        wdata_q  <= WDATA;
                        wr_q     <= hwrite;
                        master_q <= sb_masters;
                        if (off_bad) begin
                            state <= S_RESP;
                            resp  <= R_ERROR;
                        end else if (do_split) begin
                            state <= S_SPLIT;
                            resp  <= R_SPLIT;
                        end else if (acc_wait == 8'd0) begin
                            state <= S_RESP;
                            if (!hwrite) begin
                                RDATA <= mem[idx_in];
                            end
                        end else begin
                            state  <= S_BUSY;
                            cnt    <= acc_wait;
                            hready <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt <= 8'd1) begin
                        state <= S_RESP;
                        if (!wr_q) begin
                            RDATA <= mem[idx_q];
                        end
                    end else begin
                        cnt    <= cnt - 8'd1;
                        hready <= 1'b0;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                S_SPLIT: begin
                    if (scl) begin
                        resp <= R_RETRY;
                    end
                    state <= S_SBUSY;
                    cnt   <= SLOW_W8;
                end
                S_SBUSY: begin
                    if (scl) begin
                        resp <= R_RETRY;
                    end
                    if (cnt <= 8'd1) begin
                        state       <= S_SREL;
                        sb_split_ar <= master_q;
                        if (!wr_q) begin
                            split_dat <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_SREL: begin
                    if (scl) begin
                        resp <= R_RETRY;
                    end
                    state <= S_SDONE;
                end
                S_SDONE: begin
                    // Only the released master repeating its exact request completes the split.
                    if (scl) begin
                        if (same_req) begin
                            state <= S_IDLE;
                            if (!wr_q) begin
                                RDATA <= split_dat;
                            end
                        end else begin
                            resp <= R_RETRY;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_split_slave.sv
module tb_split_slave;

    logic        clk;
    logic        rst;
    logic        scl;
    logic        hwrite;
    logic [13:0] HADDR;
    logic [31:0] WDATA;
    logic [1:0]  sb_masters;
    logic        sb_mastlock;
    logic [31:0] RDATA;
    logic [1:0]  resp;
    logic        hready;
    logic [1:0]  sb_split_ar;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [1:0] M1 = 2'b01;
    localparam logic [1:0] M2 = 2'b10;

    split_slave dut (
        .clk         (clk),
        .rst         (rst),
        .scl         (scl),
        .hwrite      (hwrite),
        .HADDR       (HADDR),
        .WDATA       (WDATA),
        .sb_masters  (sb_masters),
        .sb_mastlock (sb_mastlock),
        .RDATA       (RDATA),
        .resp        (resp),
        .hready      (hready),
        .sb_split_ar (sb_split_ar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; afterwards outputs reflect that edge.
    task automatic access(input logic wr, input logic [13:0] a, input logic [31:0] d,
                          input logic [1:0] m, input logic lock);
        scl         = 1'b1;
        hwrite      = wr;
        HADDR       = a;
        WDATA       = d;
        sb_masters  = m;
        sb_mastlock = lock;
        tick();
        scl         = 1'b0;
        sb_mastlock = 1'b0;
    endtask

    // Wait-stated access: hready low for 'waits' samples, then OKAY (with data on reads).
    task automatic xfer(input string tag, input logic wr, input logic [13:0] a, input logic [31:0] d,
                        input logic [1:0] m, input logic lock, input int waits, input logic [31:0] exp_rd);
        access(wr, a, d, m, lock);
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_hready_wait"}, 32'(hready), 32'd0);
            chk({tag, "_split_ar_wait"}, 32'(sb_split_ar), 32'd0);
            tick();
        end
        chk({tag, "_hready_resp"}, 32'(hready), 32'd1);
        chk({tag, "_resp"}, 32'(resp), 32'd0);
        if (!wr) chk({tag, "_rdata"}, RDATA, exp_rd);
        tick();
    endtask

    initial begin
        rst = 1'b0; scl = 1'b0; hwrite = 1'b0; HADDR = '0; WDATA = '0;
        sb_masters = M1; sb_mastlock = 1'b0;

        // Reset held two cycles
        tick(); tick();
        chk("rst_resp",   32'(resp),        32'd0);
        chk("rst_hready", 32'(hready),      32'd1);
        chk("rst_ar",     32'(sb_split_ar), 32'd0);
        chk("rst_rdata",  RDATA,            32'd0);
        rst = 1'b1;
        tick();

        // Fast write/read, one wait state each
        xfer("fw10", 1'b1, 14'h010, 32'h0000_00A5, M1, 1'b0, 1, 32'h0);
        xfer("fr10", 1'b0, 14'h010, 32'h0,         M1, 1'b0, 1, 32'h0000_00A5);
        xfer("fw00", 1'b1, 14'h000, 32'h1111_1111, M1, 1'b0, 1, 32'h0);

        // Locked slow accesses: no split, six wait states
        xfer("sw90", 1'b1, 14'h090, 32'h0000_003C, M1, 1'b1, 6, 32'h0);
        xfer("sw94", 1'b1, 14'h094, 32'h0000_0055, M1, 1'b1, 6, 32'h0);
        xfer("sr90", 1'b0, 14'h090, 32'h0,         M1, 1'b1, 6, 32'h0000_003C);

        // Out-of-range offset 0x200: ERROR, memory at aliasing index 0 untouched
        access(1'b1, 14'h200, 32'hDEAD_BEEF, M1, 1'b0);
        chk("err_resp",   32'(resp),   32'd1);
        chk("err_hready", 32'(hready), 32'd1);
        tick();
        chk("err_resp_clr", 32'(resp), 32'd0);
        xfer("fr00", 1'b0, 14'h000, 32'h0, M1, 1'b0, 1, 32'h1111_1111);

`ifdef SLAVE_SPLIT_EN
        // Slow unlocked read by M2 is split
        access(1'b0, 14'h090, 32'h0, M2, 1'b0);
        chk("split_resp",   32'(resp),        32'd3);
        chk("split_hready", 32'(hready),      32'd1);
        chk("split_ar0",    32'(sb_split_ar), 32'd0);
        // M1 tries while split is pending
        access(1'b0, 14'h010, 32'h0, M1, 1'b0);
        chk("busy_retry",    32'(resp),        32'd2);
        chk("busy_retry_ar", 32'(sb_split_ar), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sbusy_ar", 32'(sb_split_ar), 32'd0);
        end
        tick();
        chk("srel_ar", 32'(sb_split_ar), 32'(M2));
        tick();
        chk("srel_ar_clr", 32'(sb_split_ar), 32'd0);
        // Other master in SDONE: RETRY, no memory effect
        access(1'b1, 14'h010, 32'h0000_00FF, M1, 1'b0);
        chk("sdone_retry",  32'(resp),   32'd2);
        chk("sdone_hready", 32'(hready), 32'd1);
        tick();
        chk("sdone_retry_clr", 32'(resp), 32'd0);
        // M2 re-reads and collects the stored data
        access(1'b0, 14'h090, 32'h0, M2, 1'b0);
        chk("rel_resp",   32'(resp),   32'd0);
        chk("rel_hready", 32'(hready), 32'd1);
        chk("rel_rdata",  RDATA,       32'h0000_003C);
        tick();
        xfer("fr10b", 1'b0, 14'h010, 32'h0, M1, 1'b0, 1, 32'h0000_00A5);
`else
        // Without split support a slow unlocked read just waits
        xfer("nsr90", 1'b0, 14'h090, 32'h0, M2, 1'b0, 6, 32'h0000_003C);
        xfer("fr10b", 1'b0, 14'h010, 32'h0, M1, 1'b0, 1, 32'h0000_00A5);
`endif

        // Reset in the middle of a slow unlocked write drops the write
        access(1'b1, 14'h094, 32'h0000_0077, M1, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_resp",   32'(resp),        32'd0);
        chk("mrst_hready", 32'(hready),      32'd1);
        chk("mrst_ar",     32'(sb_split_ar), 32'd0);
        tick();
        xfer("mrst_r94", 1'b0, 14'h094, 32'h0, M1, 1'b1, 6, 32'h0000_0055);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
